int_to_float: RTL and testbench
===============================

// Module: int_to_float
// PURPOSE
//  Pipelined signed-integer to IEEE-style float converter; produces {s,e,f} words in the
//  float_adder operand format (1 sign, E_bit exponent, F_bit fraction). Sits directly upstream
//  of the adder so raw integer data (ADC samples, counters) can be summed in float.
//  3-stage pipeline; valid/ready on both sides; one result per clock when not stalled.
// PARAMETERS
//  I_bit  32  input integer width, two's complement; I_bit-1 must be <= 2^(E_bit-1)-1
//  E_bit  8   exponent width
//  F_bit  23  fraction width (hidden 1 not stored)
//  E_ref  {(E_bit-1){1'b1}}  exponent bias; derived, not overridden
// PORTS
//  clk        in   1            clock, rising edge
//  rst_n      in   1            asynchronous reset, active low
//  in_data    in   I_bit        signed integer to convert
//  in_valid   in   1            in_data valid
//  in_ready   out  1            converter accepts in_data this cycle
//  out_data   out  E_bit+F_bit+1 {s,e,f} result
//  out_valid  out  1            out_data valid
//  out_ready  in   1            downstream accepts out_data this cycle
// BEHAVIOUR
//  - Reset (async, rst_n low): all stage valids, data regs, out_data, out_valid -> 0.
//    Reset mid-stream discards every in-flight word; no output after release until new input.
//  - Advance enable: en = !out_valid || out_ready. All three stages shift together when en=1;
//    otherwise every stage holds. in_ready = en (combinational). Transfer in: in_valid&in_ready;
//    out: out_valid&out_ready. Bubbles are not collapsed.
//  - Latency: exactly 3 clocks from accepted input to out_valid when en stays 1.
//  - S0: register sign s = in_data[I_bit-1]; mag = s ? -in_data : in_data as I_bit-bit
//    unsigned (most-negative input gives mag = 2^(I_bit-1), no overflow); zero flag = (mag==0).
//  - S1: casex priority encoder finds leading one, lz = leading-zero count (0..I_bit-1);
//    mag shifted left by lz so MSB = 1; exp = E_ref + (I_bit-1-lz), E_bit wide.
//  - S2: fraction = normalized bits [I_bit-2 : I_bit-1-F_bit]; if I_bit-1 < F_bit, pad LSBs
//    with 0. Dropped low bits handled per CONFIGURATION. Pack {s,exp,fraction}.
//  - Zero input: out_data = all zeros (positive zero, e = 0), regardless of rounding.
//  - No denormals, inf or NaN are produced; exponent cannot overflow under the width rule.
//  - out_data holds its value while out_valid=1 and out_ready=0.
// CONFIGURATION
//  INT_TO_FLOAT_ROUND_EN defined: round-to-nearest-even on dropped bits (guard = first dropped
//    bit, sticky = OR of rest). Round-up carrying out of the fraction sets fraction = 0 and
//    exp = exp+1. Rounding is done in S2; latency unchanged.
//  Not defined: truncate (round toward zero on magnitude), matching the adder's truncation.
// TESTING (I_bit=32, E_bit=8, F_bit=23)
//  1) in 1, then -1, 0 back-to-back, out_ready=1 -> 0x3F800000, 0xBF800000, 0x00000000 on
//     cycles 3,4,5 after first accept.
//  2) in -2147483648 -> 0xCF000000; in 2147483647 -> 0x4EFFFFFF (truncate) / 0x4F000000 (ROUND_EN).
//  3) in 16777219 -> 0x4B800001 (truncate) / 0x4B800002 (ROUND_EN, tie to even up);
//     in 16777217 -> 0x4B800000 in both builds.
//  4) Stream 10 values with out_ready toggling 1,0,0,1,... -> in_ready follows en, no word lost or
//     duplicated, out_data stable while stalled, order preserved.
//  5) Assert rst_n low with 3 words in flight -> out_valid=0 immediately; after release no stale
//     word appears; next input emerges 3 clocks after accept.

Source files
------------

// File: rtl/int_to_float.sv
// int_to_float: 3-stage pipelined signed-integer to {s,e,f} float converter.
// Ports: clk, rst_n (async, active low); in_data/in_valid/in_ready upstream;
// out_data/out_valid/out_ready downstream. All stages advance together when
// en = !out_valid || out_ready, and in_ready = en.
// Build option: define INT_TO_FLOAT_ROUND_EN for round-to-nearest-even on
// dropped magnitude bits; otherwise the magnitude is truncated.
module int_to_float #(
    parameter int I_bit = 32,
    parameter int E_bit = 8,
    parameter int F_bit = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [I_bit-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [E_bit+F_bit:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int LZW = $clog2(I_bit);
    localparam int XW  = I_bit - 1 + F_bit;
    localparam logic [E_bit-1:0] E_REF = {1'b0, {(E_bit-1){1'b1}}};

    logic en;

    // S0 state
    logic             v0_q, s0_q, z0_q;
    logic [I_bit-1:0] mag0_q;
    logic             s0_d, z0_d;
    logic [I_bit-1:0] mag0_d;

    // S1 state: normalized magnitude without the hidden one
    logic             v1_q, s1_q, z1_q;
    logic [I_bit-2:0] norm1_q;
    logic [E_bit-1:0] exp1_q;
    logic [I_bit-2:0] norm1_d;
    logic [E_bit-1:0] exp1_d;
    logic [LZW-1:0]   lz;

    // S2 state: packed result
    logic             out_valid_q;
    logic [E_bit+F_bit:0] out_data_q;
    logic [E_bit+F_bit:0] out_data_d;

    logic [XW-1:0]    ext;
    logic [F_bit-1:0] frac;
    logic [I_bit-2:0] drop;
    logic [F_bit-1:0] frac_r;
    logic [E_bit-1:0] exp_r;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // S0: sign and magnitude; most-negative input maps to 2^(I_bit-1)
    always_comb begin
        s0_d   = in_data[I_bit-1];
        mag0_d = s0_d ? (~in_data + 1'b1) : in_data;
        z0_d   = (in_data == '0);
    end

    // S1: leading-one search; highest set bit wins
    always_comb begin
        lz = '0;
        for (int i = 0; i < I_bit; i++) begin
            if (mag0_q[i]) lz = LZW'(I_bit - 1 - i);
        end
    end

    // The shifted-out MSB is the hidden one, so only the low bits are kept.
    always_comb begin
        norm1_d = mag0_q[I_bit-2:0] << lz;
        exp1_d  = E_REF + E_bit'(I_bit - 1) - E_bit'(lz);
    end

    // S2: fraction selection with zero padding when F_bit exceeds I_bit-1
    always_comb begin
        ext  = {norm1_q, {F_bit{1'b0}}};
        frac = ext[XW-1 -: F_bit];
        drop = ext[I_bit-2:0];
    end

`ifdef INT_TO_FLOAT_ROUND_EN
    logic guard, sticky, rnd_up, carry;

    always_comb begin
        guard  = drop[I_bit-2];
        sticky = |drop[I_bit-3:0];
        rnd_up = guard & (sticky | frac[0]);
        {carry, frac_r} = {1'b0, frac} + (F_bit+1)'(rnd_up);
        // carry out means frac_r wrapped to zero: bump exponent
        exp_r = exp1_q + E_bit'(carry);
    end
`else
    logic [I_bit-2:0] unused_drop;

    always_comb begin
        frac_r      = frac;
        exp_r       = exp1_q;
        unused_drop = drop;
    end
`endif

    always_comb begin
        out_data_d = z1_q ? '0 : {s1_q, exp_r, frac_r};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q        <= 1'b0;
            s0_q        <= 1'b0;
            z0_q        <= 1'b0;
            mag0_q      <= '0;
            v1_q        <= 1'b0;
            s1_q        <= 1'b0;
            z1_q        <= 1'b0;
            norm1_q     <= '0;
            exp1_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (en) begin
            v0_q        <= in_valid;
            s0_q        <= s0_d;
            z0_q        <= z0_d;
            mag0_q      <= mag0_d;
            v1_q        <= v0_q;
            s1_q        <= s0_q;
            z1_q        <= z0_q;
            norm1_q     <= norm1_d;
            exp1_q      <= exp1_d;
            out_valid_q <= v1_q;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_int_to_float.sv
// tb_int_to_float: randomized and directed checks of int_to_float against
// an arithmetic reference model and a scoreboard queue.
module tb_int_to_float;

`ifdef INT_TO_FLOAT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    int_to_float dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: value = mag, e = floor(log2 mag), keep 24 significant bits
    function automatic logic [31:0] ref_f(input logic [31:0] x);
        longint v, m, q, rem, half;
        int e, sh;
        logic s;
        v = longint'($signed(x));
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return 32'h0;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e <= 23) begin
            q = m << (23 - e);
        end else begin
            sh = e - 23;
            q = m >> sh;
            rem = m - (q << sh);
            half = 64'd1 << (sh - 1);
            if (RND && (rem > half || (rem == half && q[0]))) q++;
            if (q == (64'd1 << 24)) begin
                q = 64'd1 << 23;
                e++;
            end
        end
        return {s, 8'(e + 127), q[22:0]};
    endfunction

    // Scoreboard: every valid output must match the oldest pending word,
    // including while stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", {31'b0, in_ready},
                  {31'b0, (!out_valid || out_ready)});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious", {31'b0, out_valid}, 32'd0);
                end else begin
                    check("stream", out_data, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_f(in_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string tag, input logic [31:0] d,
                            input logic [31:0] want);
        bit took;
        int n;
        took = 1'b0;
        in_data = d;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && !took; k++) begin
            @(negedge clk);
            took = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!took) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd2);
        check(tag, out_data, want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit took;
        int idx, cyc;
        // reset state
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // back-to-back 1, -1, 0
        in_valid = 1'b1;
        in_data = 32'd1;
        out_ready = 1'b1;
        tick();
        in_data = 32'hFFFF_FFFF;
        tick();
        check("t1_early", {31'b0, out_valid}, 32'd0);
        in_data = 32'd0;
        tick();
        in_valid = 1'b0;
        check("t1_v0", {31'b0, out_valid}, 32'd1);
        check("t1_d0", out_data, 32'h3F80_0000);
        tick();
        check("t1_d1", out_data, 32'hBF80_0000);
        tick();
        check("t1_v2", {31'b0, out_valid}, 32'd1);
        check("t1_d2", out_data, 32'h0000_0000);
        tick();
        check("t1_idle", {31'b0, out_valid}, 32'd0);

        // extremes and rounding boundaries
        send_one("min_neg", 32'h8000_0000, 32'hCF00_0000);
        send_one("max_pos", 32'h7FFF_FFFF,
                 RND ? 32'h4F00_0000 : 32'h4EFF_FFFF);
        send_one("tie_up", 32'd16777219,
                 RND ? 32'h4B80_0002 : 32'h4B80_0001);
        send_one("tie_even", 32'd16777217, 32'h4B80_0000);
        send_one("small", 32'd1000, 32'h447A_0000);
        tick();

        // 10-word stream, out_ready pattern 1,0,0,1,0,0,...
        idx = 0;
        cyc = 0;
        in_valid = 1'b1;
        in_data = $urandom;
        while (idx < 10 && cyc < 200) begin
            out_ready = (cyc % 3 == 0);
            @(negedge clk);
            took = in_valid && in_ready;
            tick();
            cyc++;
            if (took) begin
                idx++;
                in_data = $urandom;
            end
        end
        in_valid = 1'b0;
        if (idx < 10) check("stream_timeout", 32'(idx), 32'd10);

        // random traffic and random backpressure
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 9) < 6);
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 9) < 7);
                case ($urandom_range(0, 3))
                    0: in_data = $urandom;
                    1: in_data = 32'($signed($urandom_range(0, 64)) - 32);
                    2: in_data = $urandom >> $urandom_range(0, 31);
                    default: in_data = -($urandom >> $urandom_range(0, 31));
                endcase
            end
            @(negedge clk);
            took = in_valid && in_ready;
            tick();
            if (took) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        check("drain", 32'(exp_q.size()), 32'd0);

        // reset with three words in flight
        in_valid = 1'b1;
        in_data = 32'd100;
        tick();
        in_data = 32'd200;
        tick();
        in_data = 32'd300;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_rst_idle", {31'b0, out_valid}, 32'd0);
        end
        send_one("post_rst", 32'hFFFF_FC18, 32'hC47A_0000);
        tick();
        repeat (3) tick();
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
